// File: rtl/rob_commit_unit_pkg.sv
// Shared types, sizes and opcode helpers for the in-order retirement stage.
package rob_commit_unit_pkg;

    localparam int unsigned ROB_LENGTH       = 16;
    localparam int unsigned ROB_IDX_W        = $clog2(ROB_LENGTH);
    localparam int unsigned INSTR_MEM_LENGTH = 256;
    localparam int unsigned INSTR_MEM_IDX_W  = $clog2(INSTR_MEM_LENGTH);
    localparam int unsigned PHYS_REG_LENGTH  = 64;
    localparam int unsigned PHYS_REG_IDX_W   = $clog2(PHYS_REG_LENGTH);
    localparam int unsigned ARCH_REG_LENGTH  = 32;
    localparam int unsigned ARCH_REG_IDX_W   = $clog2(ARCH_REG_LENGTH);
    localparam int unsigned OPCODE_W         = 7;
    localparam int unsigned RETIRED_CNT_W    = 32;
    localparam int unsigned MISPRED_CNT_W    = 16;

    typedef logic [OPCODE_W-1:0]        opcode_t;
    typedef logic [INSTR_MEM_IDX_W-1:0] pc_t;
    typedef logic [PHYS_REG_IDX_W-1:0]  phys_idx_t;
    typedef logic [ARCH_REG_IDX_W-1:0]  arch_idx_t;

    localparam opcode_t OPCODE_OP     = 7'b0110011;
    localparam opcode_t OPCODE_OP_IMM = 7'b0010011;
    localparam opcode_t OPCODE_LOAD   = 7'b0000011;
    localparam opcode_t OPCODE_STORE  = 7'b0100011;
    localparam opcode_t OPCODE_BRANCH = 7'b1100011;
    localparam opcode_t OPCODE_JAL    = 7'b1101111;
    localparam opcode_t OPCODE_JALR   = 7'b1100111;

    typedef struct packed {
        logic      valid;
        logic      done;
        opcode_t   opcode;
        pc_t       pc;
        arch_idx_t logical_rd;
        phys_idx_t phys_rd;
        phys_idx_t old_phys_rd;
        logic      pred_taken;
        pc_t       pred_target;
        logic      branch_taken;
        pc_t       branch_target;
    } rob_entry_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } commit_state_t;

    typedef struct packed {
        logic valid;
        pc_t  pc;
        logic taken;
        pc_t  target;
    } bp_update_t;

    function automatic logic is_branch_op(input opcode_t op);
        return (op == OPCODE_BRANCH) || (op == OPCODE_JAL) || (op == OPCODE_JALR);
    endfunction

    function automatic logic is_store_op(input opcode_t op);
        return op == OPCODE_STORE;
    endfunction

    // Stores and conditional branches have no destination; x0 writes are discarded.
    function automatic logic writes_rd(input rob_entry_t e);
        return (e.opcode != OPCODE_STORE) && (e.opcode != OPCODE_BRANCH) &&
               (e.logical_rd != arch_idx_t'(0));
    endfunction

endpackage

// File: rtl/rob_commit_unit_if.sv
// ROB-head / retirement-side signal bundle for rob_commit_unit.
interface rob_commit_unit_if;
    import rob_commit_unit_pkg::*;

    rob_entry_t              head_entry_i;
    logic                    rob_empty_i;
    logic                    retire_o;
    logic                    commit_valid_o;
    arch_idx_t               commit_logical_rd_o;
    phys_idx_t               commit_phys_rd_o;
    logic                    free_valid_o;
    phys_idx_t               free_phys_o;
    logic                    store_req_o;
    logic                    store_ack_i;
    logic                    flush_o;
    pc_t                     redirect_pc_o;
    logic                    bp_update_valid_o;
    pc_t                     bp_update_pc_o;
    logic                    bp_update_taken_o;
    pc_t                     bp_update_target_o;
    logic [RETIRED_CNT_W-1:0] retired_cnt_o;
    logic [MISPRED_CNT_W-1:0] mispred_cnt_o;

    modport master (
        output head_entry_i, rob_empty_i, store_ack_i,
        input  retire_o, commit_valid_o, commit_logical_rd_o, commit_phys_rd_o,
               free_valid_o, free_phys_o, store_req_o, flush_o, redirect_pc_o,
               bp_update_valid_o, bp_update_pc_o, bp_update_taken_o,
               bp_update_target_o, retired_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  head_entry_i, rob_empty_i, store_ack_i,
        output retire_o, commit_valid_o, commit_logical_rd_o, commit_phys_rd_o,
               free_valid_o, free_phys_o, store_req_o, flush_o, redirect_pc_o,
               bp_update_valid_o, bp_update_pc_o, bp_update_taken_o,
               bp_update_target_o, retired_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/rob_commit_unit_mispredict_detect.sv
// Combinational branch resolution: flags a mispredict and computes the correct fetch PC.
module mispredict_detect
    import rob_commit_unit_pkg::*;
(
    input  rob_entry_t entry,
    output logic       mispredict,
    output pc_t        redirect_pc
);

    logic dir_wrong;
    logic tgt_wrong;

    always_comb begin
        dir_wrong   = entry.pred_taken != entry.branch_taken;
        tgt_wrong   = entry.branch_taken && (entry.pred_target != entry.branch_target);
        mispredict  = is_branch_op(entry.opcode) && (dir_wrong || tgt_wrong);
        // Fall-through wraps naturally at the top of instruction memory.
        redirect_pc = entry.branch_taken ? entry.branch_target : pc_t'(entry.pc + pc_t'(1));
    end

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retirement: pops the ROB head, commits rd mappings, frees old physical
// registers, performs store handshakes and flushes on branch mispredicts.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    rob_commit_unit_if.slave bus
);

    rob_entry_t    head;
    logic          mispredict;
    pc_t           redirect;
    commit_state_t state;
    commit_state_t state_next;
    logic          retirable;
    logic          head_store;
    logic          retire_c;
    logic          store_req_c;

    logic                     commit_valid;
    arch_idx_t                commit_rd;
    phys_idx_t                commit_phys;
    logic                     free_valid;
    phys_idx_t                free_phys;
    logic                     flush;
    pc_t                      redirect_pc;
    bp_update_t               bp_update;
    logic [RETIRED_CNT_W-1:0] retired_cnt;
    logic [MISPRED_CNT_W-1:0] mispred_cnt;

    assign head       = bus.head_entry_i;
    assign retirable  = !bus.rob_empty_i && head.valid && head.done;
    assign head_store = is_store_op(head.opcode);

    mispredict_detect u_mispredict_detect (
        .entry       (head),
        .mispredict  (mispredict),
        .redirect_pc (redirect)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (retirable && head_store) begin
                    state_next = STORE_WAIT;
                end else if (retirable && mispredict) begin
                    state_next = FLUSH;
                end
            end
            STORE_WAIT: begin
                if (bus.store_ack_i) begin
                    state_next = mispredict ? FLUSH : RUN;
                end
            end
            FLUSH:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Combinational handshake outputs.
    always_comb begin
        retire_c    = 1'b0;
        store_req_c = 1'b0;
        case (state)
            RUN:        retire_c = retirable && !head_store;
            STORE_WAIT: begin
                store_req_c = 1'b1;
                retire_c    = bus.store_ack_i;
            end
            default: ;
        endcase
    end

    // Retirement side effects, one cycle after the retire edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_phys  <= '0;
            free_valid   <= 1'b0;
            free_phys    <= '0;
            flush        <= 1'b0;
            redirect_pc  <= '0;
            bp_update    <= '0;
            retired_cnt  <= '0;
            mispred_cnt  <= '0;
        end else begin
            commit_valid    <= retire_c && writes_rd(head);
            free_valid      <= retire_c && writes_rd(head);
            flush           <= retire_c && mispredict;
            bp_update.valid <= retire_c && is_branch_op(head.opcode);
            if (retire_c && writes_rd(head)) begin
                commit_rd   <= head.logical_rd;
                commit_phys <= head.phys_rd;
                free_phys   <= head.old_phys_rd;
            end
            if (retire_c && mispredict) begin
                redirect_pc <= redirect;
            end
            if (retire_c && is_branch_op(head.opcode)) begin
                bp_update.pc     <= head.pc;
                bp_update.taken  <= head.branch_taken;
                bp_update.target <= head.branch_target;
            end
            if (retire_c) begin
                retired_cnt <= retired_cnt + RETIRED_CNT_W'(1);
            end
            if (retire_c && mispredict && (mispred_cnt != {MISPRED_CNT_W{1'b1}})) begin
                mispred_cnt <= mispred_cnt + MISPRED_CNT_W'(1);
            end
        end
    end

    assign bus.retire_o            = retire_c;
    assign bus.store_req_o         = store_req_c;
    assign bus.commit_valid_o      = commit_valid;
    assign bus.commit_logical_rd_o = commit_rd;
    assign bus.commit_phys_rd_o    = commit_phys;
    assign bus.free_valid_o        = free_valid;
    assign bus.free_phys_o         = free_phys;
    assign bus.flush_o             = flush;
    assign bus.redirect_pc_o       = redirect_pc;
    assign bus.bp_update_valid_o   = bp_update.valid;
    assign bus.bp_update_pc_o      = bp_update.pc;
    assign bus.bp_update_taken_o   = bp_update.taken;
    assign bus.bp_update_target_o  = bp_update.target;
    assign bus.retired_cnt_o       = retired_cnt;
    assign bus.mispred_cnt_o       = mispred_cnt;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed, table-driven bench for rob_commit_unit plus multi-cycle corner sequences.
module tb_rob_commit_unit;
    import rob_commit_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_retired;
    int   exp_mispred;

    rob_commit_unit_if bus();

    rob_commit_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        rob_entry_t entry;
        logic       empty;
        logic       ack;
        logic       exp_retire;
        logic       exp_commit;
        logic [7:0] exp_rd;
        logic [7:0] exp_phys;
        logic [7:0] exp_free;
        logic       exp_bp;
        logic       exp_bp_taken;
        logic       exp_flush;
        logic [7:0] exp_redirect;
    } vec_t;

    vec_t vecs[10];

    function automatic rob_entry_t mk(input logic v, input logic d, input opcode_t op,
                                      input logic [7:0] pc, input logic [4:0] rd,
                                      input logic [5:0] phys, input logic [5:0] old,
                                      input logic pt, input logic [7:0] ptgt,
                                      input logic bt, input logic [7:0] btgt);
        rob_entry_t e;
        e.valid = v; e.done = d; e.opcode = op; e.pc = pc;
        e.logical_rd = rd; e.phys_rd = phys; e.old_phys_rd = old;
        e.pred_taken = pt; e.pred_target = ptgt;
        e.branch_taken = bt; e.branch_target = btgt;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rob_empty_i  = 1'b1;
        bus.store_ack_i  = 1'b0;
        bus.head_entry_i = '0;
    endtask

    task automatic chk_counters(input string name);
        chk({name, "_retired_cnt"}, bus.retired_cnt_o, 32'(exp_retired));
        chk({name, "_mispred_cnt"}, 32'(bus.mispred_cnt_o), 32'(exp_mispred));
    endtask

    initial begin
        checks = 0; errors = 0; exp_retired = 0; exp_mispred = 0;
        rst_n = 1'b0;
        idle();

        //                name        entry                                                            empty ack ret cmt rd   phys free bp bpt fl redir
        vecs[0] = '{"alu_rd5",  mk(1,1,OPCODE_OP,    8'h04,5'd5, 6'd40,6'd12,0,8'h00,0,8'h00), 0,0, 1,1,8'd5,8'd40,8'd12,0,0,0,8'h00};
        vecs[1] = '{"not_done", mk(1,0,OPCODE_OP,    8'h05,5'd6, 6'd41,6'd13,0,8'h00,0,8'h00), 0,0, 0,0,8'd0,8'd0, 8'd0, 0,0,0,8'h00};
        vecs[2] = '{"empty",    mk(1,1,OPCODE_OP,    8'h06,5'd7, 6'd42,6'd14,0,8'h00,0,8'h00), 1,0, 0,0,8'd0,8'd0, 8'd0, 0,0,0,8'h00};
        vecs[3] = '{"addi_x0",  mk(1,1,OPCODE_OP_IMM,8'h07,5'd0, 6'd43,6'd15,0,8'h00,0,8'h00), 0,0, 1,0,8'd0,8'd0, 8'd0, 0,0,0,8'h00};
        vecs[4] = '{"beq_nt",   mk(1,1,OPCODE_BRANCH,8'h20,5'd0, 6'd0, 6'd0, 1,8'h30,0,8'h30), 0,0, 1,0,8'd0,8'd0, 8'd0, 1,0,1,8'h21};
        vecs[5] = '{"jal_tgt",  mk(1,1,OPCODE_JAL,   8'hFF,5'd1, 6'd33,6'd2, 1,8'h10,1,8'h40), 0,0, 1,1,8'd1,8'd33,8'd2, 1,1,1,8'h40};
        vecs[6] = '{"beq_wrap", mk(1,1,OPCODE_BRANCH,8'hFF,5'd0, 6'd0, 6'd0, 1,8'h08,0,8'h08), 0,0, 1,0,8'd0,8'd0, 8'd0, 1,0,1,8'h00};
        vecs[7] = '{"bne_ok",   mk(1,1,OPCODE_BRANCH,8'h30,5'd0, 6'd0, 6'd0, 1,8'h50,1,8'h50), 0,0, 1,0,8'd0,8'd0, 8'd0, 1,1,0,8'h00};
        vecs[8] = '{"invalid",  mk(0,1,OPCODE_OP,    8'h31,5'd9, 6'd44,6'd16,0,8'h00,0,8'h00), 0,0, 0,0,8'd0,8'd0, 8'd0, 0,0,0,8'h00};
        vecs[9] = '{"ack_idle", mk(1,1,OPCODE_OP,    8'h32,5'd9, 6'd44,6'd16,0,8'h00,0,8'h00), 1,1, 0,0,8'd0,8'd0, 8'd0, 0,0,0,8'h00};

        step(); step();
        chk("rst_commit_valid", 32'(bus.commit_valid_o), 32'd0);
        chk("rst_flush", 32'(bus.flush_o), 32'd0);
        chk("rst_store_req", 32'(bus.store_req_o), 32'd0);
        chk_counters("rst");
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            bus.head_entry_i = vecs[i].entry;
            bus.rob_empty_i  = vecs[i].empty;
            bus.store_ack_i  = vecs[i].ack;
            #1;
            chk({vecs[i].name, "_retire"}, 32'(bus.retire_o), 32'(vecs[i].exp_retire));
            chk({vecs[i].name, "_store_req"}, 32'(bus.store_req_o), 32'd0);
            step();
            idle();
            exp_retired += int'(vecs[i].exp_retire);
            exp_mispred += int'(vecs[i].exp_flush);
            chk({vecs[i].name, "_commit_valid"}, 32'(bus.commit_valid_o), 32'(vecs[i].exp_commit));
            chk({vecs[i].name, "_free_valid"}, 32'(bus.free_valid_o), 32'(vecs[i].exp_commit));
            if (vecs[i].exp_commit) begin
                chk({vecs[i].name, "_commit_rd"}, 32'(bus.commit_logical_rd_o), 32'(vecs[i].exp_rd));
                chk({vecs[i].name, "_commit_phys"}, 32'(bus.commit_phys_rd_o), 32'(vecs[i].exp_phys));
                chk({vecs[i].name, "_free_phys"}, 32'(bus.free_phys_o), 32'(vecs[i].exp_free));
            end
            chk({vecs[i].name, "_bp_valid"}, 32'(bus.bp_update_valid_o), 32'(vecs[i].exp_bp));
            if (vecs[i].exp_bp) begin
                chk({vecs[i].name, "_bp_taken"}, 32'(bus.bp_update_taken_o), 32'(vecs[i].exp_bp_taken));
                chk({vecs[i].name, "_bp_pc"}, 32'(bus.bp_update_pc_o), 32'(vecs[i].entry.pc));
            end
            chk({vecs[i].name, "_flush"}, 32'(bus.flush_o), 32'(vecs[i].exp_flush));
            if (vecs[i].exp_flush) begin
                chk({vecs[i].name, "_redirect"}, 32'(bus.redirect_pc_o), 32'(vecs[i].exp_redirect));
            end
            chk_counters(vecs[i].name);
            step();
            chk({vecs[i].name, "_pulse_end"}, 32'({bus.commit_valid_o, bus.flush_o, bus.bp_update_valid_o}), 32'd0);
        end

        // Store handshake with ack three cycles late.
        begin
            int req_cycles;
            req_cycles = 0;
            bus.head_entry_i = mk(1,1,OPCODE_STORE,8'h40,5'd3,6'd20,6'd21,0,8'h00,0,8'h00);
            bus.rob_empty_i  = 1'b0;
            #1;
            chk("st_run_retire", 32'(bus.retire_o), 32'd0);
            step();
            for (int c = 0; c < 4; c++) begin
                bus.store_ack_i = (c == 3);
                #1;
                if (bus.store_req_o) req_cycles++;
                chk("st_wait_retire", 32'(bus.retire_o), 32'(c == 3));
                step();
            end
            idle();
            exp_retired++;
            chk("st_req_cycles", 32'(req_cycles), 32'd4);
            chk("st_req_after", 32'(bus.store_req_o), 32'd0);
            chk("st_no_commit", 32'({bus.commit_valid_o, bus.free_valid_o}), 32'd0);
            chk_counters("st");
            step();
        end

        // A ready head is held off during the flush cycle.
        bus.head_entry_i = mk(1,1,OPCODE_BRANCH,8'h20,5'd0,6'd0,6'd0,1,8'h30,0,8'h30);
        bus.rob_empty_i  = 1'b0;
        step();
        exp_retired++; exp_mispred++;
        bus.head_entry_i = mk(1,1,OPCODE_OP,8'h21,5'd4,6'd50,6'd9,0,8'h00,0,8'h00);
        #1;
        chk("fl_flush", 32'(bus.flush_o), 32'd1);
        chk("fl_redirect", 32'(bus.redirect_pc_o), 32'h21);
        chk("fl_retire_blocked", 32'(bus.retire_o), 32'd0);
        chk_counters("fl");
        idle();
        step();
        chk("fl_flush_end", 32'(bus.flush_o), 32'd0);

        // Reset while a store is waiting for its ack.
        bus.head_entry_i = mk(1,1,OPCODE_STORE,8'h50,5'd0,6'd0,6'd0,0,8'h00,0,8'h00);
        bus.rob_empty_i  = 1'b0;
        step();
        #1;
        chk("rs_in_wait", 32'(bus.store_req_o), 32'd1);
        rst_n = 1'b0;
        idle();
        step();
        exp_retired = 0; exp_mispred = 0;
        chk("rs_store_req", 32'(bus.store_req_o), 32'd0);
        chk("rs_retire", 32'(bus.retire_o), 32'd0);
        chk_counters("rs");
        rst_n = 1'b1;
        bus.store_ack_i = 1'b1;
        step();
        #1;
        chk("rs_late_ack_ignored", 32'({bus.retire_o, bus.store_req_o}), 32'd0);
        idle();
        step();
        chk_counters("rs_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_commit_unit.md
# rob_commit_unit

In-order retirement stage of the out-of-order core; it consumes the reorder buffer from the head side. Dispatch and the functional units write `rob_entry_t` entries into the ROB. This block reads the head entry and retires it when it is done. On retirement it:
- updates the retirement mapping,
- returns the superseded physical register to the free list,
- releases committed stores to data memory through a handshake,
- resolves branch predictions, issuing a pipeline flush and fetch redirect on a mispredict.

## Interface
Parameters (from `general_defines`):
- `ROB_LENGTH`, 16, ROB depth; `ROB_IDX_W` derived.
- `INSTR_MEM_LENGTH`, 256, word-indexed instruction memory; `INSTR_MEM_IDX_W` derived.
- `PHYS_REG_LENGTH`, 64; `ARCH_REG_LENGTH`, 32; index widths derived.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `head_entry_i`  in  `$bits(rob_entry_t)`  ROB head entry.
- `rob_empty_i`  in  1  ROB holds no entries.
- `retire_o`  out  1  pop ROB head at this edge (combinational).
- `commit_valid_o`  out  1  registered; architectural rd mapping update.
- `commit_logical_rd_o`  out  `ARCH_REG_IDX_W`  architectural register to update.
- `commit_phys_rd_o`  out  `PHYS_REG_IDX_W`  new physical mapping for that register.
- `free_valid_o`  out  1  registered; return a physical register to the free list.
- `free_phys_o`  out  `PHYS_REG_IDX_W`  physical register being freed (`old_phys_rd`).
- `store_req_o`  out  1  committed store request to memory.
- `store_ack_i`  in  1  memory accepted the store.
- `flush_o`  out  1  registered one-cycle flush pulse.
- `redirect_pc_o`  out  `INSTR_MEM_IDX_W`  correct fetch PC, valid with `flush_o`.
- `bp_update_valid_o`  out  1  registered predictor update.
- `bp_update_pc_o`  out  `INSTR_MEM_IDX_W`  PC of the retired branch.
- `bp_update_taken_o`  out  1  actual branch outcome.
- `bp_update_target_o`  out  `INSTR_MEM_IDX_W`  actual branch target.
- `retired_cnt_o`  out  32  retired-instruction counter, wraps.
- `mispred_cnt_o`  out  16  mispredict counter, saturates at 16'hFFFF.

## Operation
State machine states:
- **RUN.** The head is retirable when `!rob_empty_i & head.valid & head.done`.
  - A retirable non-store head gives `retire_o` = 1 in the same cycle.
  - A retirable store head moves the FSM to STORE_WAIT. `retire_o` stays 0.
- **STORE_WAIT.** `store_req_o` = 1, held until `store_ack_i`.
  - In the ack cycle, `retire_o` = 1 and the FSM returns to RUN (or goes to FLUSH, see below).
- **FLUSH.** Entered on the edge at which a mispredicted branch retires. Lasts exactly one cycle.
  - `flush_o` = 1 and `redirect_pc_o` is valid.
  - `retire_o` = 0.
  - The FSM then returns to RUN.

Destination write:
- "Writes rd" means `opcode ∉ {OPCODE_STORE, OPCODE_BRANCH}` and `logical_rd ≠ 0`.
- When a retiring instruction writes rd, the next cycle gives `commit_valid_o` = `free_valid_o` = 1, carrying `logical_rd`, `phys_rd` and `old_phys_rd`.
- An instruction with rd = x0 produces no commit and no free.

Branch handling (`is_branch` covers BRANCH, JAL and JALR):
- On retirement of a branch, the next cycle gives `bp_update_valid_o` = 1.
- Mispredict condition: `pred_taken ≠ branch_taken`, or (`branch_taken & pred_target ≠ branch_target`).
- Redirect PC: `redirect_pc_o = branch_taken ? branch_target : pc + 1`, truncated to `INSTR_MEM_IDX_W`, so it wraps at 255→0.
- A mispredicted JAL/JALR still commits its rd.
- Nothing younger retires until the ROB has been flushed by the external logic that receives `flush_o`.

Counters:
- `retired_cnt_o` increments by 1 on every `retire_o` cycle.
- `mispred_cnt_o` increments on every mispredict.

## Timing
- Throughput: at most 1 retirement per cycle; back-to-back retirement in RUN.
- Store retirement latency: 1 cycle plus the memory ack wait.
- `commit_*`, `free_*`, `bp_update_*` and `flush_o` are registered. Each is valid exactly one cycle after the `retire_o` edge and stays high for one cycle.
- `retire_o` and `store_req_o` are combinational from the state register and head inputs.
- ROB empty: `retire_o` = 0 and no request is made.
- Head valid but not done: the unit stalls.
- `store_ack_i` arriving outside STORE_WAIT is ignored.
- Reset (synchronous, `rst_n` = 0, including mid-STORE_WAIT):
  - FSM → RUN.
  - All registered outputs = 0.
  - Both counters = 0.
  - A pending store is abandoned with no retirement.

## Structure
- Add to `general_defines`:
  - `commit_state_t` enum {RUN, STORE_WAIT, FLUSH}.
  - `bp_update_t` packed struct {valid, pc, taken, target}.
- Sub-module: `mispredict_detect`. It is combinational and takes `rob_entry_t` and outputs `mispredict` and `redirect_pc`. Keeping it separate lets it be reused by an early-resolution unit.

## Test plan
- **ALU retire.** Head done, rd = 5, phys_rd = 40, old = 12 → `retire_o` = 1 in cycle 0. In cycle 1: `commit_valid_o` = 1 with rd 5/phys 40, `free_valid_o` = 1 with phys 12, and `retired_cnt_o` = 1.
- **Store handshake.** Store head done; `store_ack_i` delayed 3 cycles → `store_req_o` = 1 for 4 cycles and `retire_o` = 1 only in the ack cycle. No commit or free is produced.
- **Branch mispredict.** BEQ at pc = 0x20 with pred_taken = 1, branch_taken = 0 → the next cycle gives `flush_o` = 1, `redirect_pc_o` = 0x21, `bp_update_taken_o` = 0 and `mispred_cnt_o` = 1. The following cycle gives `retire_o` = 0 even with a ready head.
- **Target mismatch and wrap.** JAL at pc = 0xFF with rd = 1, pred_target = 0x10, branch_target = 0x40 → flush with redirect 0x40, and rd 1 commits. Separately, a not-taken mispredict at pc 0xFF → redirect 0x00.
- **Reset and x0.** Reset asserted in STORE_WAIT → the next cycle shows `store_req_o` = 0 and the counters at 0. An ADDI to x0 retires with no commit and no free.
